// File: rtl/demux2_pkg.sv
// demux2_pkg: shared constants and types for the buffered 1:2 demultiplexer.
//   CNT_W        width of the optional per-port delivery counters
//   port_t       output port index
//   PORT0/PORT1  port index values
package demux2_pkg;

  localparam int unsigned CNT_W = 16;

  typedef logic [0:0] port_t;

  localparam port_t PORT0 = 1'b0;
  localparam port_t PORT1 = 1'b1;

endpackage

// File: rtl/demux2_fifo.sv
// demux2_fifo: circular-buffer FIFO, no bypass and no pass-through.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   push, din       write request and data (ignored while full)
//   pop             read request (ignored while empty)
//   dout            head word, driven to 0 while empty
//   full, empty     registered occupancy flags
module demux2_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: dout is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/demux2_buf.sv
// demux2_buf: buffered 1:2 demultiplexer. Each accepted word goes to the
// FIFO selected by s; each output port drains its own FIFO independently.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   d, s, in_valid, in_ready   input word, destination select, handshake
//   y0, y0_valid, y0_ready     port 0 head word and handshake
//   y1, y1_valid, y1_ready     port 1 head word and handshake
//   cnt0, cnt1                 words delivered per port (DEMUX2_COUNT_EN only)
// Build option: define DEMUX2_COUNT_EN to add the delivery counters.
module demux2_buf
  import demux2_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic             y0_valid,
  input  logic             y0_ready,
  output logic [WIDTH-1:0] y1,
  output logic             y1_valid,
  input  logic             y1_ready
`ifdef DEMUX2_COUNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  port_t sel;
  logic  full0, full1, empty0, empty1;
  logic  accept, push0, push1, pop0, pop1;

  assign sel = port_t'(s);

  // Stall on the selected FIFO only; the other FIFO's room does not help.
  assign in_ready = (sel == PORT1) ? !full1 : !full0;
  assign accept   = in_valid && in_ready;
  assign push0    = accept && (sel == PORT0);
  assign push1    = accept && (sel == PORT1);

  assign y0_valid = !empty0;
  assign y1_valid = !empty1;
  assign pop0     = y0_valid && y0_ready;
  assign pop1     = y1_valid && y1_ready;

  demux2_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo0 (
    .clk  (clk),
    .reset(reset),
    .push (push0),
    .din  (d),
    .pop  (pop0),
    .dout (y0),
    .full (full0),
    .empty(empty0)
  );

  demux2_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo1 (
    .clk  (clk),
    .reset(reset),
    .push (push1),
    .din  (d),
    .pop  (pop1),
    .dout (y1),
    .full (full1),
    .empty(empty1)
  );

`ifdef DEMUX2_COUNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Free-running delivery counters; wrap naturally at 2^CNT_W.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (pop0) cnt0_d = cnt0_q + CNT_W'(1);
    if (pop1) cnt1_d = cnt1_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_demux2_buf.sv
// tb_demux2_buf: directed bench for demux2_buf (WIDTH=8, DEPTH=2). A queue
// model of the two FIFOs predicts every output each cycle; literal checks
// pin the model at the interesting points.
module tb_demux2_buf;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] d;
  logic             s;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y0, y1;
  logic             y0_valid, y1_valid;
  logic             y0_ready, y1_ready;
`ifdef DEMUX2_COUNT_EN
  logic [15:0]      cnt0, cnt1;
  logic [15:0]      m_cnt0, m_cnt1;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] q0[$], q1[$];
  logic [WIDTH-1:0] log0[$];

  always #5 clk = ~clk;

  demux2_buf #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .d       (d),
    .s       (s),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .y0      (y0),
    .y0_valid(y0_valid),
    .y0_ready(y0_ready),
    .y1      (y1),
    .y1_valid(y1_valid),
    .y1_ready(y1_ready)
`ifdef DEMUX2_COUNT_EN
    ,
    .cnt0    (cnt0),
    .cnt1    (cnt1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Compare every DUT output against the queue model.
  task automatic compare_model();
    logic [WIDTH-1:0] e0, e1;
    e0 = (q0.size() != 0) ? q0[0] : '0;
    e1 = (q1.size() != 0) ? q1[0] : '0;
    chk("y0_valid", 32'(y0_valid), 32'(q0.size() != 0));
    chk("y1_valid", 32'(y1_valid), 32'(q1.size() != 0));
    chk("y0", 32'(y0), 32'(e0));
    chk("y1", 32'(y1), 32'(e1));
    chk("in_ready", 32'(in_ready), 32'(s ? (q1.size() < DEPTH) : (q0.size() < DEPTH)));
`ifdef DEMUX2_COUNT_EN
    chk("cnt0", 32'(cnt0), 32'(m_cnt0));
    chk("cnt1", 32'(cnt1), 32'(m_cnt1));
`endif
  endtask

  // One clock cycle: drive at negedge, check, then advance the model at posedge.
  task automatic cycle(input logic v, input logic sel, input logic [WIDTH-1:0] data,
                       input logic r0, input logic r1);
    logic acc, p0, p1;
    in_valid = v;
    s        = sel;
    d        = data;
    y0_ready = r0;
    y1_ready = r1;
    #1;
    compare_model();
    acc = v && (sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH));
    p0  = r0 && (q0.size() != 0);
    p1  = r1 && (q1.size() != 0);
    @(posedge clk);
    if (p0) begin
      log0.push_back(q0.pop_front());
`ifdef DEMUX2_COUNT_EN
      m_cnt0 = m_cnt0 + 16'd1;
`endif
    end
    if (p1) begin
      void'(q1.pop_front());
`ifdef DEMUX2_COUNT_EN
      m_cnt1 = m_cnt1 + 16'd1;
`endif
    end
    if (acc) begin
      if (sel) q1.push_back(data);
      else     q0.push_back(data);
    end
    @(negedge clk);
  endtask

  initial begin
`ifdef DEMUX2_COUNT_EN
    m_cnt0 = '0;
    m_cnt1 = '0;
`endif
    reset    = 1'b1;
    d        = '0;
    s        = 1'b0;
    in_valid = 1'b0;
    y0_ready = 1'b0;
    y1_ready = 1'b0;
    #1;
    chk("rst_y0_valid", 32'(y0_valid), 32'd0);
    chk("rst_y1_valid", 32'(y1_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_y0", 32'(y0), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Steering and one-cycle latency.
    cycle(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
    chk("lit_y0_a5", {23'd0, y0_valid, y0}, {23'd0, 1'b1, 8'hA5});
    chk("lit_y1_idle", 32'(y1_valid), 32'd0);
    cycle(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
    chk("lit_y1_3c", {23'd0, y1_valid, y1}, {23'd0, 1'b1, 8'h3C});
    chk("lit_y0_idle", 32'(y0_valid), 32'd0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Fill FIFO0 and stall; port 1 keeps flowing.
    cycle(1'b1, 1'b0, 8'h01, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 8'h02, 1'b0, 1'b1);
    chk("lit_stall_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 1'b0, 8'h03, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
    chk("lit_y1_77", {23'd0, y1_valid, y1}, {23'd0, 1'b1, 8'h77});

    // Full with simultaneous pop: no pass-through, accept next cycle.
    log0.delete();
    cycle(1'b1, 1'b0, 8'h03, 1'b1, 1'b1);
    chk("lit_ready_after_pop", 32'(in_ready), 32'd1);
    cycle(1'b1, 1'b0, 8'h03, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("lit_order_n", 32'(log0.size()), 32'd3);
    for (int i = 0; i < 3 && i < log0.size(); i++) begin
      chk("lit_order", 32'(log0[i]), 32'(i + 1));
    end

    // Streaming across pointer wrap: one word per cycle, occupancy 1.
    log0.delete();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 8'(i), 1'b1, 1'b1);
      chk("lit_stream_valid", 32'(y0_valid), 32'd1);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("lit_stream_n", 32'(log0.size()), 32'd10);
    for (int i = 0; i < 10 && i < log0.size(); i++) begin
      chk("lit_stream", 32'(log0[i]), 32'(i));
    end

    // Asynchronous reset mid-stream with one word in each FIFO.
    cycle(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'hBB, 1'b0, 1'b0);
    chk("lit_pre_rst", {30'd0, y1_valid, y0_valid}, 32'd3);
    s     = 1'b0;
    reset = 1'b1;
    #1;
    chk("arst_y0_valid", 32'(y0_valid), 32'd0);
    chk("arst_y1_valid", 32'(y1_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_y0y1", {16'd0, y0, y1}, 32'd0);
    q0.delete();
    q1.delete();
`ifdef DEMUX2_COUNT_EN
    chk("arst_cnt", {cnt0, cnt1}, 32'd0);
    m_cnt0 = '0;
    m_cnt1 = '0;
`endif
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 1'b1, 8'h5A, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

`ifdef DEMUX2_COUNT_EN
    // Counter wrap: 65537 pops on port 1 after reset (one already done above).
    for (int i = 0; i < 65536; i++) begin
      cycle(1'b1, 1'b1, 8'(i), 1'b1, 1'b1);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("lit_cnt1_wrap", 32'(cnt1), 32'd1);
    chk("lit_cnt0_zero", 32'(cnt0), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
